// File: rtl/spi_secded_master_n.sv
// SPI master that exchanges one (16,11) extended-Hamming packet per request and corrects the reply.
// Define SPI_RETRY_EN to re-shift the same packet once when the first reply is uncorrectable.
module spi_secded_master_n #(
  parameter int NUM_SS = 4,
  parameter int SS_W   = 2
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              start,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic [10:0]       data_from_proc,
  input  logic              msg_in,
  output logic              msg_out,
  output logic              clk_out,
  output logic [NUM_SS-1:0] ss,
  output logic              busy,
  output logic              done,
  output logic [10:0]       data_to_proc,
  output logic              single_err,
  output logic              double_err,
  output logic              retried,
  output logic [7:0]        err_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DECODE = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic logic [15:0] secded_encode(input logic [10:0] d);
    logic [15:0] p;
    p     = 16'h0000;
    p[3]  = d[0];
    p[5]  = d[1];
    p[6]  = d[2];
    p[7]  = d[3];
    p[9]  = d[4];
    p[10] = d[5];
    p[11] = d[6];
    p[12] = d[7];
    p[13] = d[8];
    p[14] = d[9];
    p[15] = d[10];
    p[1]  = p[3] ^ p[5] ^ p[7] ^ p[9] ^ p[11] ^ p[13] ^ p[15];
    p[2]  = p[3] ^ p[6] ^ p[7] ^ p[10] ^ p[11] ^ p[14] ^ p[15];
    p[4]  = p[5] ^ p[6] ^ p[7] ^ p[12] ^ p[13] ^ p[14] ^ p[15];
    p[8]  = p[9] ^ p[10] ^ p[11] ^ p[12] ^ p[13] ^ p[14] ^ p[15];
    p[0]  = ^p[15:1];
    return p;
  endfunction

  function automatic logic [3:0] secded_syndrome(input logic [15:0] c);
    logic [3:0] s;
    s = 4'd0;
    for (int i = 1; i < 16; i++) begin
      s = s ^ (c[i] ? 4'(i) : 4'd0);
    end
    return s;
  endfunction

  function automatic logic [10:0] secded_extract(input logic [15:0] c);
    return {c[15:9], c[7:5], c[3]};
  endfunction

  state_t            r_state;
  logic [15:0]       r_tx;
  logic [15:0]       r_rx;
  logic [3:0]        r_cnt;
  logic [NUM_SS-1:0] r_ss;
  logic              r_busy;
  logic              r_done;
  logic [10:0]       r_data;
  logic              r_single;
  logic              r_double;
  logic [7:0]        r_err_cnt;
`ifdef SPI_RETRY_EN
  logic [15:0]       r_pkt;
  logic              r_second;
  logic              r_retried;
`endif

  logic [15:0]       w_pkt;
  logic [15:0]       w_flip;
  logic [15:0]       w_fixed;
  logic [3:0]        w_syn;
  logic              w_par;
  logic              w_double;
  logic              w_sel_ok;
  logic              w_load;
  logic              w_final;
  logic [NUM_SS-1:0] w_ss_dec;

  // Encoder, syndrome decoder, slave-select decode and request qualification.
  always_comb begin
    w_pkt    = secded_encode(data_from_proc);
    w_syn    = secded_syndrome(r_rx);
    w_par    = ^r_rx;
    w_flip   = 16'h0001 << w_syn;
    if (w_par) begin
      w_fixed = r_rx ^ w_flip;
    end else begin
      w_fixed = r_rx;
    end
    w_double = !w_par && (w_syn != 4'd0);
    w_sel_ok = (32'(ss_sel) < 32'(NUM_SS));
    w_ss_dec = {NUM_SS{1'b0}};
    for (int i = 0; i < NUM_SS; i++) begin
      w_ss_dec[i] = (32'(ss_sel) == 32'(i));
    end
    // DONE also accepts a request so back-to-back frames run every 18 cycles
    w_load = start && w_sel_ok && ((r_state == IDLE) || (r_state == DONE));
`ifdef SPI_RETRY_EN
    w_final = !(w_double && !r_second);
`else
    w_final = 1'b1;
`endif
  end

  // Transaction FSM with all outputs held in registers.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state   <= IDLE;
      r_tx      <= 16'h0000;
      r_rx      <= 16'h0000;
      r_cnt     <= 4'd0;
      r_ss      <= {NUM_SS{1'b0}};
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_data    <= 11'h000;
      r_single  <= 1'b0;
      r_double  <= 1'b0;
      r_err_cnt <= 8'd0;
`ifdef SPI_RETRY_EN
      r_pkt     <= 16'h0000;
      r_second  <= 1'b0;
      r_retried <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_state  <= SHIFT;
        r_tx     <= w_pkt;
        r_cnt    <= 4'd0;
        r_ss     <= w_ss_dec;
        r_busy   <= 1'b1;
`ifdef SPI_RETRY_EN
        r_pkt    <= w_pkt;
        r_second <= 1'b0;
`endif
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= IDLE;
          end
          SHIFT: begin
            r_tx  <= {r_tx[14:0], 1'b0};
            r_rx  <= {r_rx[14:0], msg_in};
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) begin
              r_state <= DECODE;
            end
          end
          DECODE: begin
            if (w_final) begin
              r_data   <= secded_extract(w_fixed);
              r_single <= w_par;
              r_double <= w_double;
              if (w_par && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
              end
`ifdef SPI_RETRY_EN
              r_retried <= r_second;
`endif
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
`ifdef SPI_RETRY_EN
              r_second <= 1'b1;
              r_tx     <= r_pkt;
              r_state  <= SHIFT;
`else
              r_state  <= IDLE;
`endif
            end
          end
          DONE: begin
            r_ss    <= {NUM_SS{1'b0}};
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign msg_out      = r_tx[15];
  assign clk_out      = clk_in;
  assign ss           = r_ss;
  assign busy         = r_busy;
  assign done         = r_done;
  assign data_to_proc = r_data;
  assign single_err   = r_single;
  assign double_err   = r_double;
  assign err_cnt      = r_err_cnt;
`ifdef SPI_RETRY_EN
  assign retried      = r_retried;
`else
  assign retried      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_secded_master_n.sv
// Directed table-driven bench for spi_secded_master_n; packets below are hand-encoded constants.
module tb_spi_secded_master_n;
  localparam int NSS = 4;
  localparam int SW  = 3;
  localparam int NV  = 8;

  typedef struct {
    logic [SW-1:0]  sel;
    logic [10:0]    din;
    logic [15:0]    f1;
    logic [15:0]    f2;
    bit             lb;
    int             poke;
    logic [15:0]    pkt;
    logic [NSS-1:0] ss;
    logic [10:0]    dout;
    logic           s;
    logic           d;
    logic           r;
    logic [7:0]     cnt;
    int             last;
  } vec_t;

  logic clk = 1'b0;
  logic reset, start, loopback, miso_drv, msg_in_w;
  logic [SW-1:0] ss_sel;
  logic [10:0] data_from_proc;
  logic msg_out, clk_out, busy, done, single_err, double_err, retried;
  logic [NSS-1:0] ss;
  logic [10:0] data_to_proc;
  logic [7:0] err_cnt;

  int total = 0;
  int bad = 0;
  int g_done_edge, g_done_cnt, g_ss_bad;
  logic [15:0] g_mosi;
  logic [10:0] g_dout;
  logic g_s, g_d, g_r;
  logic [7:0] g_cnt;
  vec_t vt[NV];
  vec_t sat;

  assign msg_in_w = loopback ? msg_out : miso_drv;
  always #5 clk = ~clk;

  spi_secded_master_n #(.NUM_SS(NSS), .SS_W(SW)) dut (
    .clk_in(clk), .reset(reset), .start(start), .ss_sel(ss_sel),
    .data_from_proc(data_from_proc), .msg_in(msg_in_w), .msg_out(msg_out),
    .clk_out(clk_out), .ss(ss), .busy(busy), .done(done),
    .data_to_proc(data_to_proc), .single_err(single_err), .double_err(double_err),
    .retried(retried), .err_cnt(err_cnt)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  // One request, then 40 cycles of slave driving / observation indexed by edge E_e.
  task automatic run_txn(input vec_t v);
    @(negedge clk);
    start = 1'b1; ss_sel = v.sel; data_from_proc = v.din; loopback = v.lb; miso_drv = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    g_done_edge = -1; g_done_cnt = 0; g_ss_bad = 0; g_mosi = 16'h0000;
    for (int e = 0; e < 40; e++) begin
      if (e < 16) miso_drv = v.f1[15-e];
      else if (e >= 17 && e < 33) miso_drv = v.f2[32-e];
      else miso_drv = 1'b0;
      if (e == v.poke) begin
        start = 1'b1; ss_sel = 3'd0; data_from_proc = 11'h7FF;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (e < 16) g_mosi[15-e] = msg_out;
      if (done === 1'b1) begin
        g_done_cnt++;
        if (g_done_edge < 0) begin
          g_done_edge = e; g_dout = data_to_proc; g_s = single_err;
          g_d = double_err; g_r = retried; g_cnt = err_cnt;
        end
      end
      if (e <= v.last) begin
        if (ss !== v.ss || busy !== 1'b1) g_ss_bad++;
      end else if (e == v.last + 1) begin
        if (ss !== {NSS{1'b0}} || busy !== 1'b0) g_ss_bad++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_vec(input int i, input vec_t v);
    run_txn(v);
    chk($sformatf("v%0d mosi", i), g_mosi, v.pkt);
    chk($sformatf("v%0d done_edge", i), g_done_edge, v.last);
    chk($sformatf("v%0d done_pulses", i), g_done_cnt, 1);
    chk($sformatf("v%0d ss_busy_window", i), g_ss_bad, 0);
    chk($sformatf("v%0d data", i), g_dout, v.dout);
    chk($sformatf("v%0d single", i), g_s, v.s);
    chk($sformatf("v%0d double", i), g_d, v.d);
    chk($sformatf("v%0d retried", i), g_r, v.r);
    chk($sformatf("v%0d err_cnt", i), g_cnt, v.cnt);
    chk($sformatf("v%0d data_hold", i), data_to_proc, v.dout);
  endtask

  initial begin
    // B42D = enc(5A3), FFFF = enc(7FF), 000F = enc(001), 0000 = enc(000)
    vt[0] = '{3'd2, 11'h5A3, 16'h0000, 16'h0000, 1'b1, -1, 16'hB42D, 4'b0100, 11'h5A3, 1'b0, 1'b0, 1'b0, 8'd0, 17};
    vt[1] = '{3'd0, 11'h7FF, 16'hFDFF, 16'h0000, 1'b0, -1, 16'hFFFF, 4'b0001, 11'h7FF, 1'b1, 1'b0, 1'b0, 8'd1, 17};
`ifdef SPI_RETRY_EN
    vt[2] = '{3'd1, 11'h001, 16'h1007, 16'h000F, 1'b0, -1, 16'h000F, 4'b0010, 11'h001, 1'b0, 1'b0, 1'b1, 8'd1, 34};
`else
    vt[2] = '{3'd1, 11'h001, 16'h1007, 16'h0000, 1'b0, -1, 16'h000F, 4'b0010, 11'h080, 1'b0, 1'b1, 1'b0, 8'd1, 17};
`endif
    vt[3] = '{3'd3, 11'h000, 16'h000F, 16'h0000, 1'b0, -1, 16'h0000, 4'b1000, 11'h001, 1'b0, 1'b0, 1'b0, 8'd1, 17};
    vt[4] = '{3'd0, 11'h5A3, 16'hFFFE, 16'h0000, 1'b0, -1, 16'hB42D, 4'b0001, 11'h7FF, 1'b1, 1'b0, 1'b0, 8'd2, 17};
    vt[5] = '{3'd2, 11'h001, 16'h0007, 16'h0000, 1'b0, -1, 16'h000F, 4'b0100, 11'h001, 1'b1, 1'b0, 1'b0, 8'd3, 17};
    vt[6] = '{3'd3, 11'h7FF, 16'h0000, 16'h0000, 1'b1, -1, 16'hFFFF, 4'b1000, 11'h7FF, 1'b0, 1'b0, 1'b0, 8'd3, 17};
    vt[7] = '{3'd2, 11'h5A3, 16'h0000, 16'h0000, 1'b1, 5, 16'hB42D, 4'b0100, 11'h5A3, 1'b0, 1'b0, 1'b0, 8'd3, 17};
    sat   = '{3'd0, 11'h7FF, 16'hFDFF, 16'h0000, 1'b0, -1, 16'hFFFF, 4'b0001, 11'h7FF, 1'b1, 1'b0, 1'b0, 8'd0, 17};

    reset = 1'b1; start = 1'b0; ss_sel = 3'd0; data_from_proc = 11'h000;
    loopback = 1'b0; miso_drv = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst busy", busy, 1'b0);
    chk("rst ss", ss, 4'b0000);
    chk("rst done", done, 1'b0);
    chk("rst mosi", msg_out, 1'b0);
    chk("rst data", data_to_proc, 11'h000);
    chk("rst flags", {single_err, double_err, retried}, 3'b000);
    chk("rst err_cnt", err_cnt, 8'd0);
    chk("clk_out low", clk_out, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("clk_out high", clk_out, 1'b1);

    for (int i = 0; i < NV; i++) check_vec(i, vt[i]);

    // Out-of-range selects (including the boundary NUM_SS) must be dropped silently.
    for (int k = 4; k < 6; k++) begin
      int act;
      act = 0;
      @(negedge clk);
      start = 1'b1; ss_sel = SW'(k); data_from_proc = 11'h123;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (busy !== 1'b0 || ss !== 4'b0000 || done !== 1'b0) act++;
        @(negedge clk);
      end
      chk($sformatf("bad_sel%0d activity", k), act, 0);
      chk($sformatf("bad_sel%0d data_hold", k), data_to_proc, 11'h5A3);
    end

    // Reset sampled at E8 of SHIFT.
    @(negedge clk);
    start = 1'b1; ss_sel = 3'd2; data_from_proc = 11'h5A3; loopback = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst busy", busy, 1'b0);
    chk("midrst ss", ss, 4'b0000);
    chk("midrst mosi", msg_out, 1'b0);
    chk("midrst err_cnt", err_cnt, 8'd0);
    chk("midrst data", data_to_proc, 11'h000);
    reset = 1'b0;
    check_vec(100, vt[0]);

    for (int k = 0; k < 300; k++) begin
      run_txn(sat);
      if (k == 99)  chk("sat cnt100", err_cnt, 8'd100);
      if (k == 254) chk("sat cnt255", err_cnt, 8'd255);
      if (k == 299) chk("sat hold255", err_cnt, 8'd255);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
